// File: rtl/fpau_pkg.sv
// Shared FPAU definitions: IEEE-754 single-precision constants,
// the iterative-unit FSM encoding and operand classification.
package fpau_pkg;

    localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;
    localparam logic [7:0]  EXP_MAX = 8'hFF;
    localparam int          BIAS    = 127;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        FP_ZERO   = 2'd0,
        FP_NORMAL = 2'd1,
        FP_INF    = 2'd2,
        FP_NAN    = 2'd3
    } fpClass_t;

    // Denormals are folded into zero: this unit never produces or consumes them.
    function automatic fpClass_t fp_class(input logic [31:0] x);
        fpClass_t cls;
        if (x[30:23] == 8'h00) begin
            cls = FP_ZERO;
        end else if (x[30:23] == EXP_MAX) begin
            if (x[22:0] != 23'h0) begin
                cls = FP_NAN;
            end else begin
                cls = FP_INF;
            end
        end else begin
            cls = FP_NORMAL;
        end
        return cls;
    endfunction

endpackage

// File: rtl/fp32_mul_seq_if.sv
// Operand/result handshake bundle of the iterative FP32 multiplier.
// master = producer/consumer side, slave = the multiplier.
interface fp32_mul_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] s;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, s
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, s
    );
endinterface

// File: rtl/mant_mul_iter.sv
// Shift-add mantissa multiplier. Retires BITS_PER_CYC multiplier bits per
// step, LSB first. Only the bits above the truncation point leave the block.
module mant_mul_iter #(
    parameter int MANT_W       = 24,
    parameter int BITS_PER_CYC = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic [MANT_W-1:0] mantA,
    input  logic [MANT_W-1:0] mantB,
    output logic [MANT_W:0]   productHi,
    output logic              done
);
    localparam int STEPS = MANT_W / BITS_PER_CYC;
    localparam int CNT_W = $clog2(STEPS + 1);
    localparam int PROD_W = 2 * MANT_W;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STEPS - 1);

    logic [PROD_W-1:0] acc_r;
    logic [PROD_W-1:0] mcand_r;
    logic [MANT_W-1:0] mplier_r;
    logic [CNT_W-1:0]  count_r;
    logic              done_r;
    logic [PROD_W-1:0] addend_s;

    // Partial product for the multiplier bits retired this step.
    always_comb begin
        addend_s = '0;
        for (int k = 0; k < BITS_PER_CYC; k++) begin
            if (mplier_r[k]) begin
                addend_s = addend_s + (mcand_r << k);
            end else begin
                addend_s = addend_s;
            end
        end
    end

    // Accumulator, shifting operands and step counter; done latches after the last step.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r    <= '0;
            mcand_r  <= '0;
            mplier_r <= '0;
            count_r  <= '0;
            done_r   <= 1'b0;
        end else if (load) begin
            acc_r    <= '0;
            mcand_r  <= {{MANT_W{1'b0}}, mantA};
            mplier_r <= mantB;
            count_r  <= '0;
            done_r   <= 1'b0;
        end else if (step && !done_r) begin
            acc_r    <= acc_r + addend_s;
            mcand_r  <= mcand_r << BITS_PER_CYC;
            mplier_r <= mplier_r >> BITS_PER_CYC;
            count_r  <= count_r + CNT_W'(1);
            done_r   <= (count_r == LAST_CNT);
        end else begin
            acc_r    <= acc_r;
            mcand_r  <= mcand_r;
            mplier_r <= mplier_r;
            count_r  <= count_r;
            done_r   <= done_r;
        end
    end

    assign productHi = acc_r[PROD_W-1:MANT_W-1];
    assign done      = done_r;
endmodule

// File: rtl/fp32_mul_seq.sv
// Iterative IEEE-754 single-precision multiplier, round-toward-zero,
// no denormal output. Fixed latency regardless of operand class.
module fp32_mul_seq
    import fpau_pkg::*;
#(
    parameter int EXP_W        = 8,
    parameter int FRAC_W       = 23,
    parameter int BIAS         = fpau_pkg::BIAS,
    parameter int BITS_PER_CYC = 1
) (
    input  logic          clk,
    input  logic          rst,
    fp32_mul_seq_if.slave bus
);
    localparam int MANT_W = FRAC_W + 1;
    localparam int E_W    = EXP_W + 2;
    localparam logic signed [E_W-1:0] BIAS_S = E_W'(BIAS);
    localparam logic signed [E_W-1:0] EMAX_S = E_W'((1 << EXP_W) - 1);
    localparam logic signed [E_W-1:0] ONE_S  = E_W'(1);
    localparam logic signed [E_W-1:0] ZERO_S = E_W'(0);

    state_t                 state_r, nextState_s;
    logic [31:0]            opA_r, opB_r, s_r, result_s;
    logic                   load_s, step_s, iterDone_s, sign_s;
    logic [MANT_W:0]        prodHi_s;
    logic [FRAC_W-1:0]      frac_s;
    logic signed [E_W-1:0]  expSum_s, expNorm_s;
    fpClass_t               clsA_s, clsB_s;

    mant_mul_iter #(
        .MANT_W       (MANT_W),
        .BITS_PER_CYC (BITS_PER_CYC)
    ) uMant (
        .clk       (clk),
        .rst       (rst),
        .load      (load_s),
        .step      (step_s),
        .mantA     ({1'b1, bus.a[FRAC_W-1:0]}),
        .mantB     ({1'b1, bus.b[FRAC_W-1:0]}),
        .productHi (prodHi_s),
        .done      (iterDone_s)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= nextState_s;
        end
    end

    // Next-state and datapath controls; DONE never accepts, even on out_ready.
    always_comb begin
        nextState_s = state_r;
        load_s      = 1'b0;
        step_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.in_valid) begin
                    nextState_s = MUL;
                    load_s      = 1'b1;
                end else begin
                    nextState_s = IDLE;
                end
            end
            MUL: begin
                step_s = 1'b1;
                if (iterDone_s) begin
                    nextState_s = NORM;
                end else begin
                    nextState_s = MUL;
                end
            end
            NORM: nextState_s = DONE;
            DONE: begin
                if (bus.out_ready) begin
                    nextState_s = IDLE;
                end else begin
                    nextState_s = DONE;
                end
            end
            default: nextState_s = IDLE;
        endcase
    end

    // Operand capture on accept; producer need not hold them afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            opA_r <= 32'h0;
            opB_r <= 32'h0;
        end else if (load_s) begin
            opA_r <= bus.a;
            opB_r <= bus.b;
        end else begin
            opA_r <= opA_r;
            opB_r <= opB_r;
        end
    end

    // Exponent, normalisation by one place, and special-operand override.
    always_comb begin
        sign_s   = opA_r[31] ^ opB_r[31];
        clsA_s   = fp_class(opA_r);
        clsB_s   = fp_class(opB_r);
        expSum_s = $signed({2'b00, opA_r[FRAC_W +: EXP_W]})
                 + $signed({2'b00, opB_r[FRAC_W +: EXP_W]}) - BIAS_S;
        if (prodHi_s[MANT_W]) begin
            frac_s    = prodHi_s[MANT_W-1:1];
            expNorm_s = expSum_s + ONE_S;
        end else begin
            frac_s    = prodHi_s[MANT_W-2:0];
            expNorm_s = expSum_s;
        end

        if (clsA_s == FP_NAN || clsB_s == FP_NAN) begin
            result_s = FP_QNAN;
        end else if ((clsA_s == FP_INF && clsB_s == FP_ZERO) ||
                     (clsA_s == FP_ZERO && clsB_s == FP_INF)) begin
            result_s = FP_QNAN;
        end else if (clsA_s == FP_INF || clsB_s == FP_INF) begin
            result_s = {sign_s, EXP_MAX, {FRAC_W{1'b0}}};
        end else if (clsA_s == FP_ZERO || clsB_s == FP_ZERO) begin
            result_s = {sign_s, {(EXP_W + FRAC_W){1'b0}}};
        end else if (expNorm_s >= EMAX_S) begin
            result_s = {sign_s, EXP_MAX, {FRAC_W{1'b0}}};
        end else if (expNorm_s <= ZERO_S) begin
            result_s = {sign_s, {(EXP_W + FRAC_W){1'b0}}};
        end else begin
            result_s = {sign_s, expNorm_s[EXP_W-1:0], frac_s};
        end
    end

    // Result register: loaded once in NORM and held through DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_r <= 32'h0;
        end else if (state_r == NORM) begin
            s_r <= result_s;
        end else begin
            s_r <= s_r;
        end
    end

    assign bus.in_ready  = (state_r == IDLE);
    assign bus.out_valid = (state_r == DONE);
    assign bus.s         = s_r;
endmodule

// File: tb/tb_fp32_mul_seq.sv
// Directed bench for fp32_mul_seq: results, fixed latency, backpressure
// and mid-operation reset, all against hand-computed values.
module tb_fp32_mul_seq;
    logic clk;
    logic rst;
    int   checkCount;
    int   errorCount;
    int   lat;

    fp32_mul_seq_if bus();

    fp32_mul_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global watchdog so the run always ends.
    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] want);
        checkCount++;
        if (got !== want) begin
            errorCount++;
            $display("FAIL %s: got %08h expected %08h", tag, got, want);
        end
    endtask

    task automatic startOp(input string tag, input logic [31:0] opA, input logic [31:0] opB);
        for (int i = 0; i < 100 && !bus.in_ready; i++) begin
            @(posedge clk);
            #1;
        end
        checkVal({tag, "_rdy"}, {31'b0, bus.in_ready}, 32'd1);
        bus.a        = opA;
        bus.b        = opB;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic waitResult(output int cycles);
        cycles = 0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic releaseResult(input string tag);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        checkVal({tag, "_ovl"}, {31'b0, bus.out_valid}, 32'd0);
        checkVal({tag, "_idle"}, {31'b0, bus.in_ready}, 32'd1);
    endtask

    task automatic runOp(input string tag, input logic [31:0] opA, input logic [31:0] opB,
                         input logic [31:0] want);
        int cyc;
        startOp(tag, opA, opB);
        waitResult(cyc);
        checkVal({tag, "_lat"}, 32'(cyc), 32'd26);
        checkVal({tag, "_s"}, bus.s, want);
        releaseResult(tag);
    endtask

    initial begin
        checkCount    = 0;
        errorCount    = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = 32'h0;
        bus.b         = 32'h0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkVal("rst_inrdy", {31'b0, bus.in_ready}, 32'd1);
        checkVal("rst_ovl", {31'b0, bus.out_valid}, 32'd0);
        checkVal("rst_s", bus.s, 32'h0);
        rst = 1'b0;

        // Normal path and normalisation shift.
        runOp("mul2x3", 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000);
        runOp("mul15sq", 32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000);
        // Special operands.
        runOp("neginf", 32'hBF80_0000, 32'h7F80_0000, 32'hFF80_0000);
        runOp("zeroinf", 32'h0000_0000, 32'h7F80_0000, 32'h7FC0_0000);
        runOp("nan", 32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000);
        // Overflow / underflow.
        runOp("ovf", 32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000);
        runOp("unf", 32'h0080_0000, 32'h0080_0000, 32'h0000_0000);
        runOp("unfneg", 32'h8080_0000, 32'h0080_0000, 32'h8000_0000);

        // Backpressure with a second request already waiting.
        startOp("bp", 32'h4000_0000, 32'h4040_0000);
        waitResult(lat);
        checkVal("bp_lat", 32'(lat), 32'd26);
        bus.a        = 32'h3FC0_0000;
        bus.b        = 32'h3FC0_0000;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checkVal("bp_hold_s", bus.s, 32'h40C0_0000);
            checkVal("bp_hold_rdy", {31'b0, bus.in_ready}, 32'd0);
            checkVal("bp_hold_ovl", {31'b0, bus.out_valid}, 32'd1);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        checkVal("bp_rel_rdy", {31'b0, bus.in_ready}, 32'd1);
        checkVal("bp_rel_ovl", {31'b0, bus.out_valid}, 32'd0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        checkVal("b2b_busy", {31'b0, bus.in_ready}, 32'd0);
        waitResult(lat);
        checkVal("b2b_lat", 32'(lat), 32'd26);
        checkVal("b2b_s", bus.s, 32'h4010_0000);
        releaseResult("b2b");

        // Reset in the middle of an operation discards it.
        startOp("mrst", 32'h4000_0000, 32'h4040_0000);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkVal("mrst_rdy", {31'b0, bus.in_ready}, 32'd1);
        checkVal("mrst_ovl", {31'b0, bus.out_valid}, 32'd0);
        checkVal("mrst_s", bus.s, 32'h0);
        lat = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) lat++;
        end
        checkVal("mrst_noresult", 32'(lat), 32'd0);
        runOp("postrst", 32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end
endmodule
